boton_antirrebote: RTL and testbench

//  Produces the button events consumed by the tamagotchi state/mode FSM (Boton_Comida, Boton_Medicina, ...).

---
 rtl/boton_antirrebote_if.sv | 25 ++
 rtl/boton_antirrebote.sv | 121 ++++++++++++
 tb/tb_boton_antirrebote.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boton_antirrebote_if.sv
// Button event bus between one conditioned pushbutton and its consumer.
// The raw input comes in; the debounced level and event pulses go out.
interface boton_antirrebote_if;
  logic boton_in;
  logic nivel;
  logic pulso;
  logic pulso_largo;
  logic pulso_corto;

  modport master (
    output boton_in,
    input  nivel,
    input  pulso,
    input  pulso_largo,
    input  pulso_corto
  );

  modport slave (
    input  boton_in,
    output nivel,
    output pulso,
    output pulso_largo,
    output pulso_corto
  );
endinterface

// File: rtl/boton_antirrebote.sv
// Pushbutton conditioner: 2-FF synchroniser, debounce FSM, debounced level,
// and one-cycle press / long-press / short-release pulses.
module boton_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20,
  parameter bit ACTIVO_BAJO     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  boton_antirrebote_if.slave bus
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] DEB_PRESS   = 3'd1;
  localparam logic [2:0] PRESSED     = 3'd2;
  localparam logic [2:0] LONG_HELD   = 3'd3;
  localparam logic [2:0] DEB_RELEASE = 3'd4;

  logic              sync1;
  logic              sync2;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  logic              largo;
  logic              nivel_q;
  logic              pulso_q;
  logic              pulso_largo_q;
  logic              pulso_corto_q;

  // Pulses default low every cycle; hold is frozen while debouncing a release
  // so a bounce during a held press only delays the long-press event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      largo         <= 1'b0;
      nivel_q       <= 1'b0;
      pulso_q       <= 1'b0;
      pulso_largo_q <= 1'b0;
      pulso_corto_q <= 1'b0;
    end else begin
      sync1         <= bus.boton_in ^ ACTIVO_BAJO;
      sync2         <= sync1;
      pulso_q       <= 1'b0;
      pulso_largo_q <= 1'b0;
      pulso_corto_q <= 1'b0;

      case (state)
        IDLE: begin
          if (sync2) begin
            state <= DEB_PRESS;
            cnt   <= CNT_W'(1);
          end
        end

        DEB_PRESS: begin
          if (!sync2) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state   <= PRESSED;
            pulso_q <= 1'b1;
            nivel_q <= 1'b1;
            hold    <= '0;
            largo   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (!sync2) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_W'(1);
          end else if (hold == HOLD_MAX) begin
            state         <= LONG_HELD;
            pulso_largo_q <= 1'b1;
            largo         <= 1'b1;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end

        LONG_HELD: begin
          if (!sync2) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_W'(1);
          end
        end

        DEB_RELEASE: begin
          if (sync2) begin
            state <= largo ? LONG_HELD : PRESSED;
          end else if (cnt == CNT_MAX) begin
            state         <= IDLE;
            nivel_q       <= 1'b0;
            pulso_corto_q <= ~largo;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.nivel       = nivel_q;
  assign bus.pulso       = pulso_q;
  assign bus.pulso_largo = pulso_largo_q;
  assign bus.pulso_corto = pulso_corto_q;

endmodule

// File: tb/tb_boton_antirrebote.sv
// Directed bench for boton_antirrebote (D=4, L=20) with an active-high and an
// active-low instance; the active-low one sees the inverted raw input.
module tb_boton_antirrebote;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  boton_antirrebote_if bus ();
  boton_antirrebote_if bus_ab ();

  assign bus_ab.boton_in = ~bus.boton_in;

  boton_antirrebote #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVO_BAJO(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  boton_antirrebote #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVO_BAJO(1'b1)) dut_ab (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ab)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs packed as {nivel, pulso, pulso_largo, pulso_corto}.
  task automatic test_reset();
    logic [3:0] got;
    bus.boton_in = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_hold k=%0d got=%b exp=0000", k, got);
      end
    end
    bus.boton_in = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_after k=%0d got=%b exp=0000", k, got);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] got;
    bus.boton_in = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) bus.boton_in = 1'b0;
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL glitch k=%0d got=%b exp=0000", k, got);
      end
    end
  endtask

  task automatic test_short_press();
    logic [3:0] got;
    logic [3:0] exp;
    bus.boton_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      exp = {k >= 7, k == 7, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL short_press k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    bus.boton_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      exp = {k < 7, 1'b0, 1'b0, k == 7};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL short_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [3:0] got;
    logic [3:0] exp;
    bus.boton_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      exp = {k >= 7, k == 7, k == 27, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL long_press k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    bus.boton_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      exp = {k < 7, 1'b0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL long_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  // A two-cycle release bounce after acceptance only delays pulso_largo a few edges.
  task automatic test_bounce();
    logic [2:0] got;
    logic [2:0] exp;
    int largo_count = 0;
    int largo_edge = 0;
    for (int k = 1; k <= 40; k++) begin
      bus.boton_in = (k == 11 || k == 12) ? 1'b0 : 1'b1;
      tick();
      if (bus.pulso_largo === 1'b1) begin
        largo_count++;
        largo_edge = k;
      end
      got = {bus.nivel, bus.pulso, bus.pulso_corto};
      exp = {k >= 7, k == 7, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL bounce k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    total++;
    if (largo_count !== 1 || largo_edge < 27 || largo_edge > 30) begin
      bad++;
      $display("[TB] FAIL bounce_largo count=%0d edge=%0d exp count=1 edge 27..30",
               largo_count, largo_edge);
    end
    bus.boton_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_corto};
      exp = {k < 7, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL bounce_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_long_held();
    logic [3:0] got;
    logic [3:0] exp;
    bus.boton_in = 1'b1;
    for (int k = 1; k <= 30; k++) tick();
    total++;
    if (bus.nivel !== 1'b1) begin
      bad++;
      $display("[TB] FAIL held_before_reset got=%b exp=1", bus.nivel);
    end
    reset = 1'b0;
    tick();
    got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_reset got=%b exp=0000", got);
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      exp = {k >= 7, k == 7, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL repress k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    bus.boton_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus.nivel, bus.pulso, bus.pulso_largo, bus.pulso_corto};
      exp = {k < 7, 1'b0, 1'b0, k == 7};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL repress_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_activo_bajo();
    logic [3:0] got;
    logic [3:0] exp;
    bus.boton_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus_ab.nivel, bus_ab.pulso, bus_ab.pulso_largo, bus_ab.pulso_corto};
      exp = {k >= 7, k == 7, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL ab_press k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    bus.boton_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      got = {bus_ab.nivel, bus_ab.pulso, bus_ab.pulso_largo, bus_ab.pulso_corto};
      exp = {k < 7, 1'b0, 1'b0, k == 7};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL ab_release k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    bus.boton_in = 1'b0;
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_bounce();
    test_reset_long_held();
    test_activo_bajo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
